assoc_cache: RTL and testbench

ASSOC_CACHE -- requirements
Module: assoc_cache

---
 rtl/lc3b_types.sv | 8 +
 rtl/plru_tree.sv | 41 ++++
 rtl/assoc_cache.sv | 175 +++++++++++++++++
 tb/tb_assoc_cache.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b bus types used by the cache and its neighbours.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;
    typedef logic [1:0]   lc3b_mem_wmask;

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: node n has children 2n+1 (lower ways) and
// 2n+2 (upper ways); a node bit of 0 points the victim search at the lower half.
module plru_tree #(
    parameter int WAYS = 2
) (
    input  logic [WAYS-2:0]         bits_in,
    input  logic [$clog2(WAYS)-1:0] access_way,
    output logic [WAYS-2:0]         bits_out,
    output logic [$clog2(WAYS)-1:0] victim_way
);

    localparam int LW = $clog2(WAYS);

    int unsigned node_a;
    int unsigned node_v;
    logic        dir_a;
    logic        dir_v;

    // Walk the tree twice in parallel: follow the bits to find the victim, and
    // follow the accessed way's path pointing every node on it away from that way.
    always_comb begin
        bits_out   = bits_in;
        victim_way = '0;
        node_a     = 0;
        node_v     = 0;
        dir_a      = 1'b0;
        dir_v      = 1'b0;
        for (int unsigned lvl = 0; lvl < LW; lvl++) begin
            dir_a = access_way[LW-1-lvl];
            dir_v = 1'b0;
            for (int unsigned n = 0; n < WAYS - 1; n++) begin
                if (n == node_v) dir_v = bits_in[n];
                if (n == node_a) bits_out[n] = ~dir_a;
            end
            victim_way[LW-1-lvl] = dir_v;
            node_a = 2 * node_a + 1 + 32'(dir_a);
            node_v = 2 * node_v + 1 + 32'(dir_v);
        end
    end

endmodule

// File: rtl/assoc_cache.sv
// Write-back, write-allocate set-associative cache with zero-wait hits,
// tree-PLRU replacement and hit/miss counters.
module assoc_cache
    import lc3b_types::*;
#(
    parameter int WAYS     = 2,
    parameter int SET_BITS = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_read,
    input  logic          mem_write,
    input  lc3b_word      mem_address,
    input  lc3b_word      mem_wdata,
    input  lc3b_mem_wmask mem_byte_enable,
    output lc3b_word      mem_rdata,
    output logic          mem_resp,
    output logic          pmem_read,
    output logic          pmem_write,
    output lc3b_word      pmem_address,
    output lc3b_line      pmem_wdata,
    input  lc3b_line      pmem_rdata,
    input  logic          pmem_resp,
    output logic [15:0]   hit_count,
    output logic [15:0]   miss_count
);

    localparam int SETS  = 2 ** SET_BITS;
    localparam int TAG_W = 12 - SET_BITS;
    localparam int WW    = $clog2(WAYS);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] FILL      = 2'd2;

    lc3b_line          data_arr  [WAYS][SETS];
    logic [TAG_W-1:0]  tag_arr   [WAYS][SETS];
    logic [WAYS-1:0]   valid_arr [SETS];
    logic [WAYS-1:0]   dirty_arr [SETS];
    logic [WAYS-2:0]   plru_arr  [SETS];

    logic [1:0]          state;
    logic [WW-1:0]       victim_q;
    logic [11:0]         line_q;
    logic                retry_q;

    logic [SET_BITS-1:0] set_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [2:0]          word_sel;
    logic                req;
    logic                hit;
    logic [WW-1:0]       hit_way;
    logic                inv_found;
    logic [WW-1:0]       inv_way;
    logic [WW-1:0]       plru_victim;
    logic [WW-1:0]       miss_victim;
    logic [WAYS-2:0]     plru_next;
    lc3b_line            hit_line;
    lc3b_line            wr_line;
    logic [SET_BITS-1:0] fill_set;
    logic [TAG_W-1:0]    fill_tag;
    logic                unused_addr_lsb;

    assign set_idx         = mem_address[3+SET_BITS:4];
    assign req_tag         = mem_address[15:4+SET_BITS];
    assign word_sel        = mem_address[3:1];
    assign req             = mem_read | mem_write;
    assign fill_set        = line_q[SET_BITS-1:0];
    assign fill_tag        = line_q[11:SET_BITS];
    assign unused_addr_lsb = mem_address[0];

    plru_tree #(.WAYS(WAYS)) u_plru (
        .bits_in    (plru_arr[set_idx]),
        .access_way (hit_way),
        .bits_out   (plru_next),
        .victim_way (plru_victim)
    );

    // Tag compare across all ways, plus lowest-index invalid way for allocation.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!hit && valid_arr[set_idx][w] && (tag_arr[w][set_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
            if (!inv_found && !valid_arr[set_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WW'(w);
            end
        end
    end

    // Read word selection and byte-lane merge of write data into the hit line.
    always_comb begin
        hit_line    = data_arr[hit_way][set_idx];
        mem_rdata   = hit_line[{word_sel, 4'h0} +: 16];
        wr_line     = hit_line;
        if (mem_byte_enable[0]) wr_line[{word_sel, 4'h0} +: 8] = mem_wdata[7:0];
        if (mem_byte_enable[1]) wr_line[{word_sel, 4'h8} +: 8] = mem_wdata[15:8];
        miss_victim = inv_found ? inv_way : plru_victim;
    end

    // Bus-side outputs; the writeback address is rebuilt from the victim's stored tag.
    always_comb begin
        mem_resp     = (state == IDLE) && req && hit;
        pmem_read    = (state == FILL);
        pmem_write   = (state == WRITEBACK);
        pmem_wdata   = data_arr[victim_q][fill_set];
        pmem_address = {line_q, 4'h0};
        if (state == WRITEBACK) pmem_address = {tag_arr[victim_q][fill_set], fill_set, 4'h0};
    end

    // Controller, metadata and counters; retry_q marks the post-fill retry so it is not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            victim_q   <= '0;
            line_q     <= '0;
            retry_q    <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
                plru_arr[s]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    retry_q <= 1'b0;
                    if (req) begin
                        if (hit) begin
                            plru_arr[set_idx] <= plru_next;
                            if (mem_write) dirty_arr[set_idx][hit_way] <= 1'b1;
                            if (!retry_q) hit_count <= hit_count + 16'd1;
                        end else begin
                            miss_count <= miss_count + 16'd1;
                            victim_q   <= miss_victim;
                            line_q     <= mem_address[15:4];
                            state      <= dirty_arr[set_idx][miss_victim] ? WRITEBACK : FILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) state <= FILL;
                end
                FILL: begin
                    if (pmem_resp) begin
                        valid_arr[fill_set][victim_q] <= 1'b1;
                        dirty_arr[fill_set][victim_q] <= 1'b0;
                        retry_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data and tag storage; deliberately not reset.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && req && hit && mem_write) begin
            data_arr[hit_way][set_idx] <= wr_line;
        end
        if ((state == FILL) && pmem_resp && !rst) begin
            data_arr[victim_q][fill_set] <= pmem_rdata;
            tag_arr[victim_q][fill_set]  <= fill_tag;
        end
    end

endmodule

// File: tb/tb_assoc_cache.sv
// Self-checking bench for assoc_cache (WAYS=4, SET_BITS=3): directed scenarios
// with literal expectations, then randomized traffic against a reference model.
module tb_assoc_cache;
    import lc3b_types::*;

    localparam int WAYS = 4;
    localparam int SET_BITS = 3;
    localparam int SETS = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_read, mem_write;
    lc3b_word      mem_address, mem_wdata, mem_rdata, pmem_address;
    lc3b_mem_wmask mem_byte_enable;
    logic          mem_resp, pmem_read, pmem_write, pmem_resp;
    lc3b_line      pmem_wdata, pmem_rdata;
    logic [15:0]   hit_count, miss_count;

    always #5 clk = ~clk;

    assoc_cache #(.WAYS(WAYS), .SET_BITS(SET_BITS)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Backing store seen by the DUT (phys_m) and the model's own view (ref_m).
    logic [127:0] phys_m [int unsigned];
    logic [127:0] ref_m  [int unsigned];

    function automatic logic [127:0] pat_line(input int unsigned l);
        logic [127:0] r;
        for (int w = 0; w < 8; w++) r[w*16 +: 16] = 16'(l * 8 + 32'(w)) ^ 16'hC3A5;
        return r;
    endfunction

    function automatic logic [127:0] phys_get(input int unsigned l);
        return phys_m.exists(l) ? phys_m[l] : pat_line(l);
    endfunction

    function automatic logic [127:0] ref_get(input int unsigned l);
        return ref_m.exists(l) ? ref_m[l] : pat_line(l);
    endfunction

    // Reference cache: per-set arrays plus a 3-bit tree {right pair, left pair, root}.
    bit           m_valid [SETS][WAYS];
    bit           m_dirty [SETS][WAYS];
    int unsigned  m_tag   [SETS][WAYS];
    logic [127:0] m_data  [SETS][WAYS];
    bit [2:0]     m_tree  [SETS];
    int unsigned  m_hits, m_misses;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_tree[s] = 3'b000;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
        m_hits = 0;
        m_misses = 0;
    endtask

    function automatic int model_victim(input int s);
        for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
        return m_tree[s][0] ? 2 + int'(m_tree[s][2]) : int'(m_tree[s][1]);
    endfunction

    task automatic model_touch(input int s, input int w);
        m_tree[s][0] = (w < 2);
        if (w < 2) m_tree[s][1] = (w == 0);
        else       m_tree[s][2] = (w == 2);
    endtask

    // Memory responder: 0..2 idle cycles, then a one-cycle pmem_resp.
    int lat;
    initial begin
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        lat = 1;
        forever begin
            @(negedge clk);
            if (rst) begin
                pmem_resp = 1'b0;
                lat = 1;
            end else if (pmem_resp) begin
                pmem_resp = 1'b0;
                lat = $urandom_range(0, 2);
            end else if (pmem_read || pmem_write) begin
                if (lat == 0) begin
                    pmem_resp = 1'b1;
                    if (pmem_write) phys_m[32'(pmem_address[15:4])] = pmem_wdata;
                    else pmem_rdata = phys_get(32'(pmem_address[15:4]));
                end else begin
                    lat--;
                end
            end
        end
    end

    // Observations of the most recent access, used for literal expectations.
    logic [15:0]  last_rdata, last_fill_addr, last_wb_addr;
    logic [127:0] last_wb_data;
    bit           last_first_resp, last_seen_wb;

    task automatic access(input bit rd, input bit wr, input logic [15:0] a,
                          input logic [15:0] wd, input logic [1:0] be);
        int unsigned s, t, wo, line;
        int hw, vw;
        bit exp_hit, exp_wb, seen_wb, seen_rd, got;
        logic [15:0] exp_wb_addr;
        logic [127:0] exp_wb_data;
        s = 32'(a[6:4]); t = 32'(a[15:7]); wo = 32'(a[3:1]); line = 32'(a[15:4]);
        hw = -1; vw = 0; exp_wb = 1'b0; exp_wb_addr = '0; exp_wb_data = '0;
        for (int w = 0; w < WAYS; w++)
            if (hw < 0 && m_valid[s][w] && m_tag[s][w] == t) hw = w;
        exp_hit = (hw >= 0);
        if (!exp_hit) begin
            vw = model_victim(int'(s));
            exp_wb = m_valid[s][vw] && m_dirty[s][vw];
            exp_wb_addr = 16'(m_tag[s][vw] * 128 + s * 16);
            exp_wb_data = m_data[s][vw];
        end
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_address = a; mem_wdata = wd; mem_byte_enable = be;
        #1;
        last_first_resp = mem_resp;
        chk("first_lookup_resp", mem_resp, exp_hit);
        seen_wb = 0; seen_rd = 0; got = 0;
        for (int c = 0; c < 60 && !got; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            chk("pmem_exclusive", pmem_read & pmem_write, 0);
            chk("resp_only_idle", mem_resp & (pmem_read | pmem_write), 0);
            if (pmem_write && !seen_wb) begin
                seen_wb = 1;
                last_wb_addr = pmem_address;
                last_wb_data = pmem_wdata;
                chk("wb_addr", pmem_address, exp_wb_addr);
                chk("wb_data", pmem_wdata, exp_wb_data);
            end
            if (pmem_read && !seen_rd) begin
                seen_rd = 1;
                last_fill_addr = pmem_address;
                chk("fill_addr", pmem_address, 16'(line * 16));
                chk("wb_before_fill", seen_wb, exp_wb);
            end
            if (mem_resp) got = 1;
        end
        chk("resp_within_bound", got, 1);
        chk("fill_seen", seen_rd, !exp_hit);
        chk("wb_seen", seen_wb, exp_wb);
        last_seen_wb = seen_wb;
        last_rdata = mem_rdata;
        if (exp_hit) m_hits++;
        else begin
            m_misses++;
            if (exp_wb) ref_m[m_tag[s][vw] * 8 + s] = exp_wb_data;
            m_data[s][vw] = ref_get(line);
            m_tag[s][vw] = t;
            m_valid[s][vw] = 1'b1;
            m_dirty[s][vw] = 1'b0;
            hw = vw;
        end
        if (!wr) chk("rdata", mem_rdata, m_data[s][hw][wo*16 +: 16]);
        else begin
            if (be[0]) m_data[s][hw][wo*16 +: 8] = wd[7:0];
            if (be[1]) m_data[s][hw][wo*16+8 +: 8] = wd[15:8];
            m_dirty[s][hw] = 1'b1;
        end
        model_touch(int'(s), hw);
        @(posedge clk);
        @(negedge clk);
        mem_read = 0; mem_write = 0;
        #1;
        chk("idle_resp", mem_resp, 0);
        chk("idle_pmem", {pmem_read, pmem_write}, 0);
        chk("hit_count", hit_count, 16'(m_hits));
        chk("miss_count", miss_count, 16'(m_misses));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        logic [127:0] l123;
        rst = 1'b1;
        mem_read = 0; mem_write = 0; mem_address = '0; mem_wdata = '0; mem_byte_enable = '0;
        model_reset();
        l123 = pat_line(32'h123);
        l123[47:32] = 16'h5A5A;
        phys_m[32'h123] = l123;
        ref_m[32'h123] = l123;
        #1;
        chk("por_mem_resp", mem_resp, 0);
        chk("por_pmem", {pmem_read, pmem_write}, 0);
        chk("por_counts", {hit_count, miss_count}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Cold read miss, then hit, then byte-lane write.
        access(1, 0, 16'h1234, 16'h0, 2'b00);
        chk("lit_fill_addr", last_fill_addr, 16'h1230);
        chk("lit_rdata_5a5a", last_rdata, 16'h5A5A);
        chk("lit_miss1", miss_count, 16'd1);
        chk("lit_hit0", hit_count, 16'd0);
        access(1, 0, 16'h1234, 16'h0, 2'b00);
        chk("lit_zero_wait", last_first_resp, 1);
        chk("lit_hit1", hit_count, 16'd1);
        access(0, 1, 16'h1234, 16'hABCD, 2'b01);
        access(1, 0, 16'h1234, 16'h0, 2'b00);
        chk("lit_merge", last_rdata, 16'h5ACD);

        // Fill the remaining ways of set 3, then force PLRU evictions.
        access(1, 0, 16'h0030, 16'h0, 2'b00);
        access(1, 0, 16'h00B0, 16'h0, 2'b00);
        access(1, 0, 16'h0130, 16'h0, 2'b00);
        chk("lit_no_wb_while_invalid", last_seen_wb, 0);
        access(1, 0, 16'h01B0, 16'h0, 2'b00);
        chk("lit_wb_addr", last_wb_addr, 16'h1230);
        chk("lit_wb_word", last_wb_data[47:32], 16'h5ACD);
        chk("lit_fill_after_wb", last_fill_addr, 16'h01B0);
        access(1, 0, 16'h0230, 16'h0, 2'b00);
        chk("lit_clean_evict", last_seen_wb, 0);
        chk("lit_miss_total", miss_count, 16'd6);

        // Randomized traffic over a small tag pool so sets conflict often.
        for (int i = 0; i < 300; i++) begin
            int op;
            logic [15:0] a;
            op = $urandom_range(0, 3);
            a = 16'($urandom_range(0, 5) * 128 + $urandom_range(0, 7) * 16 +
                    $urandom_range(0, 7) * 2 + $urandom_range(0, 1));
            access(op < 2, op >= 2, a, 16'($urandom), 2'($urandom));
        end

        // Reset during FILL abandons the fill; the same address misses afterwards.
        do_reset();
        @(negedge clk);
        mem_read = 1; mem_address = 16'h7770;
        #1;
        for (int c = 0; c < 20 && !pmem_read; c++) begin @(negedge clk); #1; end
        chk("midfill_reached", pmem_read, 1);
        rst = 1'b1;
        #1;
        chk("midfill_read_drop", pmem_read, 0);
        chk("midfill_resp", mem_resp, 0);
        mem_read = 0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        access(1, 0, 16'h7770, 16'h0, 2'b00);
        chk("lit_post_reset_miss", last_first_resp, 0);
        chk("lit_post_reset_count", miss_count, 16'd1);
        access(1, 0, 16'h7770, 16'h0, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
